// File: rtl/swap_seq_if.sv
// Handshake and write-port bundle between the control unit, the swap sequencer
// and the register-file write arbiter.
interface swap_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) ();
    logic              start;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              wr_gnt;
    logic              busy;
    logic              done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start_err;

    modport master (
        output start, rs_addr, rt_addr, rs_data, rt_data, wr_gnt,
        input  busy, done, wr_req, wr_addr, wr_data, start_err
    );

    modport slave (
        input  start, rs_addr, rt_addr, rs_data, rt_data, wr_gnt,
        output busy, done, wr_req, wr_addr, wr_data, start_err
    );
endinterface

// File: rtl/swap_seq.sv
// SWAP sequencer: snapshots RS/RT and writes each value back to the other's address.
// Optional SWAP_SAME_SKIP_EN: a swap with rs_addr==rt_addr skips both writes.
module swap_seq #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input logic        clk,
    input logic        rst,
    swap_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_RS = 2'd1,
        WR_RT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;

    logic              busy_q;
    logic              done_q;
    logic              wr_req_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic              start_err_q;
    logic              same_skip;

`ifdef SWAP_SAME_SKIP_EN
    assign same_skip = (bus.rs_addr == bus.rt_addr);
`else
    assign same_skip = 1'b0;
`endif

    // NOTE: all state and outputs use non-blocking assignments so every branch
    // sees the pre-edge values; the async reset clears every register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_reg       <= '0;
            b_reg       <= '0;
            a_addr      <= '0;
            b_addr      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_req_q    <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            start_err_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            start_err_q <= bus.start && (state != IDLE);

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg  <= bus.rs_data;
                        b_reg  <= bus.rt_data;
                        a_addr <= bus.rs_addr;
                        b_addr <= bus.rt_addr;
                        if (same_skip) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state     <= WR_RS;
                            busy_q    <= 1'b1;
                            wr_req_q  <= 1'b1;
                            wr_addr_q <= bus.rs_addr;
                            wr_data_q <= bus.rt_data;
                        end
                    end
                end

                WR_RS: begin
                    if (bus.wr_gnt) begin
                        state     <= WR_RT;
                        wr_addr_q <= b_addr;
                        wr_data_q <= a_reg;
                    end else begin
                        wr_addr_q <= a_addr;
                        wr_data_q <= b_reg;
                    end
                end

                WR_RT: begin
                    // Second write still uses the snapshot, not the updated RS.
                    if (bus.wr_gnt) begin
                        state     <= DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        wr_req_q  <= 1'b0;
                        wr_addr_q <= '0;
                        wr_data_q <= '0;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wr_req    = wr_req_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.start_err = start_err_q;

endmodule

// File: tb/tb_swap_seq.sv
// Scoreboard bench for swap_seq: expected writes, done and start_err pulses are
// queued with their cycle numbers and matched by a negedge monitor.
module tb_swap_seq;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;

    wr_exp_t wr_q[$];
    int      done_q[$];
    int      err_q[$];

    swap_seq_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    swap_seq #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_wr(input int c, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_exp_t e;
        e.cyc  = c;
        e.addr = a;
        e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic issue_start(input logic [ADDR_W-1:0] ra, input logic [DATA_W-1:0] rd,
                               input logic [ADDR_W-1:0] ta, input logic [DATA_W-1:0] td);
        bus.rs_addr = ra;
        bus.rs_data = rd;
        bus.rt_addr = ta;
        bus.rt_data = td;
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
    endtask

    // Monitor: a committed write is any cycle with wr_req and wr_gnt both high.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_req && bus.wr_gnt) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h at cycle %0d", bus.wr_addr, bus.wr_data, cyc);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check("write_cycle", cyc, e.cyc);
                    check("write_addr", 32'(bus.wr_addr), 32'(e.addr));
                    check("write_data", bus.wr_data, e.data);
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    check("done_cycle", cyc, done_q.pop_front());
                end
            end
            if (bus.start_err) begin
                if (err_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start_err: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    check("start_err_cycle", cyc, err_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        checks = 0;
        errors = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.rs_addr = '0;
        bus.rt_addr = '0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        bus.wr_gnt  = 1'b1;
        step();
        step();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_wr_req", 32'(bus.wr_req), 0);
        check("rst_wr_addr", 32'(bus.wr_addr), 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_start_err", 32'(bus.start_err), 0);
        rst = 1'b0;
        step();

        // 1: basic swap, grant tied high
        s = cyc;
        exp_wr(s + 1, 4'd3, 32'h2222_2222);
        exp_wr(s + 2, 4'd7, 32'h1111_1111);
        done_q.push_back(s + 3);
        issue_start(4'd3, 32'h1111_1111, 4'd7, 32'h2222_2222);
        check("t1_busy", 32'(bus.busy), 1);
        step();
        step();
        check("t1_busy_done", 32'(bus.busy), 0);
        step();

        // 4: back-to-back start in cycle 4, inputs zeroed after capture
        s = cyc;
        exp_wr(s + 1, 4'd1, 32'h4444_4444);
        exp_wr(s + 2, 4'd2, 32'h3333_3333);
        done_q.push_back(s + 3);
        issue_start(4'd1, 32'h3333_3333, 4'd2, 32'h4444_4444);
        bus.rs_data = '0;
        bus.rt_data = '0;
        step();
        step();
        step();

        // 2: three-cycle stall in WR_RS
        bus.wr_gnt = 1'b0;
        s = cyc;
        exp_wr(s + 4, 4'd3, 32'h2222_2222);
        exp_wr(s + 5, 4'd7, 32'h1111_1111);
        done_q.push_back(s + 6);
        issue_start(4'd3, 32'h1111_1111, 4'd7, 32'h2222_2222);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.wr_gnt = 1'b1;
            check("t2_hold_req", 32'(bus.wr_req), 1);
            check("t2_hold_addr", 32'(bus.wr_addr), 3);
            check("t2_hold_data", bus.wr_data, 32'h2222_2222);
            step();
        end
        step();
        step();

        // 3: start while busy and while in DONE
        s = cyc;
        exp_wr(s + 1, 4'd3, 32'h2222_2222);
        exp_wr(s + 2, 4'd7, 32'h1111_1111);
        done_q.push_back(s + 3);
        err_q.push_back(s + 2);
        err_q.push_back(s + 4);
        issue_start(4'd3, 32'h1111_1111, 4'd7, 32'h2222_2222);
        issue_start(4'd9, 32'hDEAD_BEEF, 4'd10, 32'hCAFE_F00D);
        step();
        issue_start(4'd9, 32'hDEAD_BEEF, 4'd10, 32'hCAFE_F00D);
        step();
        step();

        // 5: same address
        s = cyc;
`ifdef SWAP_SAME_SKIP_EN
        done_q.push_back(s + 1);
        issue_start(4'd5, 32'hA5A5_A5A5, 4'd5, 32'hA5A5_A5A5);
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_wr_req", 32'(bus.wr_req), 0);
`else
        exp_wr(s + 1, 4'd5, 32'hA5A5_A5A5);
        exp_wr(s + 2, 4'd5, 32'hA5A5_A5A5);
        done_q.push_back(s + 3);
        issue_start(4'd5, 32'hA5A5_A5A5, 4'd5, 32'hA5A5_A5A5);
        check("t5_busy", 32'(bus.busy), 1);
        check("t5_wr_req", 32'(bus.wr_req), 1);
`endif
        step();
        step();
        step();

        // 6: async reset while stalled in WR_RT
        s = cyc;
        exp_wr(s + 1, 4'd3, 32'h2222_2222);
        issue_start(4'd3, 32'h1111_1111, 4'd7, 32'h2222_2222);
        step();
        bus.wr_gnt = 1'b0;
        check("t6_in_wr_rt_addr", 32'(bus.wr_addr), 7);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_wr_req", 32'(bus.wr_req), 0);
        check("t6_rst_wr_addr", 32'(bus.wr_addr), 0);
        check("t6_rst_wr_data", bus.wr_data, 0);
        check("t6_rst_busy", 32'(bus.busy), 0);
        step();
        rst = 1'b0;
        bus.wr_gnt = 1'b1;
        step();
        s = cyc;
        exp_wr(s + 1, 4'd2, 32'h6666_6666);
        exp_wr(s + 2, 4'd4, 32'h5555_5555);
        done_q.push_back(s + 3);
        issue_start(4'd2, 32'h5555_5555, 4'd4, 32'h6666_6666);
        step();
        step();
        step();
        step();

        check("leftover_writes", wr_q.size(), 0);
        check("leftover_done", done_q.size(), 0);
        check("leftover_start_err", err_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/swap_seq.md
Name: swap_seq

Overview:
- Parametrised swap sequencer for the SISC datapath.
- On a SWAP instruction it captures the RS and RT operand values and their register addresses in one clock.
- It then drives the register-file write port over two write cycles: old RT value to RS address, old RS value to RT address.
- Handshakes with the control unit (start/busy/done) and with the register-file write arbiter (wr_req/wr_gnt), so write-back can be stalled.

Parameters:
DATA_W, 32, width of operand data and write data
ADDR_W, 4, width of register address (2**ADDR_W registers)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a swap; sampled only in IDLE
rs_addr  input  ADDR_W  RS register address, captured with start
rt_addr  input  ADDR_W  RT register address, captured with start
rs_data  input  DATA_W  RS operand value, captured with start
rt_data  input  DATA_W  RT operand value, captured with start
wr_gnt  input  1  register-file write port granted this cycle
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse after the second write is granted
wr_req  output  1  write request to the register-file write port
wr_addr  output  ADDR_W  write address
wr_data  output  DATA_W  write data
start_err  output  1  one-cycle pulse when start arrives while not IDLE

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - busy=0, done=0, wr_req=0, wr_addr=0, wr_data=0, start_err=0.
  - Captured registers cleared to 0; state=IDLE.
- States: IDLE, WR_RS, WR_RT, DONE.
- IDLE:
  - With start=1, capture a_reg<=rs_data, b_reg<=rt_data, a_addr<=rs_addr, b_addr<=rt_addr, then go to WR_RS.
  - Inputs are ignored otherwise.
- WR_RS:
  - Drive wr_req=1, wr_addr=a_addr, wr_data=b_reg.
  - Stay until wr_gnt=1, then go to WR_RT.
- WR_RT:
  - Drive wr_req=1, wr_addr=b_addr, wr_data=a_reg.
  - Stay until wr_gnt=1, then go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. A start in DONE is treated as not-IDLE.
- busy=1 in WR_RS and WR_RT.
- Outputs are registered: wr_req/wr_addr/wr_data reflect the current state.
- wr_data and wr_addr hold stable while wr_req=1 and wr_gnt=0.
- Latency with wr_gnt tied high:
  - start at cycle 0 gives WR_RS write in cycle 1, WR_RT write in cycle 2, done in cycle 3.
  - Next start is accepted in cycle 4.
- Each wr_gnt cycle while wr_req=1 counts as exactly one committed write. wr_gnt while wr_req=0 is ignored.
- start while state≠IDLE:
  - Request is dropped; captured values are unchanged.
  - start_err pulses for one cycle, the cycle after.
- The captured snapshot is independent of later rs_data/rt_data changes. Write values are the pre-swap values even though the first write modifies RS.
- rs_addr==rt_addr (no SWAP_SAME_SKIP_EN): both writes are performed. The register ends holding its own original value.
- Reset mid-operation: immediate return to IDLE with all outputs zero; the pending swap is abandoned. If the first write was already granted, the register file stays partially swapped; this is accepted.
- All data paths are DATA_W bits with no arithmetic. Addresses are compared at full ADDR_W width.

Optional Feature:
SWAP_SAME_SKIP_EN
- Defined:
  - At start acceptance, if rs_addr==rt_addr, go directly IDLE→DONE.
  - No wr_req is issued, busy stays 0, and done pulses on the cycle after start.
- Not defined: the same-address swap performs both writes as described above.

Test Plan:
1. Reset then basic swap, wr_gnt=1. Start with rs_addr=3, rs_data=0x11111111, rt_addr=7, rt_data=0x22222222.
   - Cycle 1: wr_addr=3, wr_data=0x22222222.
   - Cycle 2: wr_addr=7, wr_data=0x11111111.
   - Cycle 3: done=1.
2. Stall. Same stimulus as 1, wr_gnt=0 for 3 cycles in WR_RS.
   - wr_req=1, wr_addr=3 and wr_data=0x22222222 are held for 4 cycles.
   - The second write follows the grant; done is 3 cycles later than in 1.
3. Busy collision. Second start with rs_data=0xDEADBEEF while busy.
   - start_err pulses once.
   - Writes still carry 0x22222222/0x11111111; no extra writes occur.
4. Input change after capture. Change rs_data/rt_data to 0 the cycle after start.
   - Write data is unchanged from the captured values.
5. Same address. rs_addr=rt_addr=5, data 0xA5A5A5A5.
   - Without the macro: two writes to 5 of 0xA5A5A5A5, done in cycle 3.
   - With SWAP_SAME_SKIP_EN: no wr_req, done in cycle 1.
6. Reset mid-operation. Assert rst asynchronously while in WR_RT with wr_gnt=0.
   - Outputs go to 0 immediately.
   - After release, a new start is accepted with 1-cycle latency to first write.
